// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the MIPS fetch sequencer.
// Holds the FSM state encoding and the PC alignment/range check used by the top.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StHold,
    StLoad,
    StFault
  } fetch_state_t;

  localparam int unsigned BYTES_PER_INST = 4;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // True when a fetch at pc would be misaligned or run past the end of memory.
  // Computed in 33 bits so pc near 2^32 cannot wrap back into range.
  function automatic logic pc_bad(input logic [31:0] pc, input int unsigned mem_bytes);
    logic [32:0] last;
    last = {1'b0, pc} + 33'(BYTES_PER_INST - 1);
    return (pc[1:0] != 2'b00) || (last >= 33'(mem_bytes));
  endfunction

endpackage

// File: rtl/inst_byte_assembler.sv
// Four-byte shift register that builds a big-endian instruction word.
// The first byte captured ends up in the most significant byte.
module inst_byte_assembler
  import fetch_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  logic [BYTES_PER_INST-1:0][7:0] bytes_q, bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (clr_i) begin
      bytes_d = '0;
    end else if (cap_i) begin
      bytes_d = {bytes_q[BYTES_PER_INST-2:0], byte_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bytes_q <= '0;
    end else begin
      bytes_q <= bytes_d;
    end
  end

  assign word_o = bytes_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: reads four bytes per instruction over a byte-wide port,
// hands the word to decode over valid/ready, and arbitrates the port with a loader.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MEM_BYTES = 400,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_wr_en_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_wdata_i,
  output logic              ld_gnt_o,
  input  logic              redir_valid_i,
  input  logic [31:0]       redir_pc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_word_o,
  output logic [31:0]       inst_pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic              fault_o
);

  fetch_state_t state_q, state_d;
  logic [1:0]   k_q, k_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         inst_valid_q, inst_valid_d;
  logic         fault_q, fault_d;
  logic         asm_clr, asm_cap;

  // The assembler register doubles as the inst_word output register: its last
  // byte lands in DRAIN and it is left untouched while the word is held.
  inst_byte_assembler u_asm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (asm_clr),
    .cap_i  (asm_cap),
    .byte_i (mem_rdata_i),
    .word_o (inst_word_o)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    pc_plus4_d  = pc_plus4_q;
    asm_clr     = 1'b0;
    asm_cap     = 1'b0;
    mem_addr_o  = '0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_wdata_o = '0;
    ld_gnt_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ld_req_i) begin
          state_d = StLoad;
        end else if (pc_bad(pc_q, MEM_BYTES)) begin
          state_d = StFault;
        end else begin
          state_d = StFetch;
          k_d     = 2'd0;
        end
      end
      StFetch: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = pc_q[ADDR_W-1:0] + ADDR_W'(k_q);
        // Read data trails the address by one cycle, so k=0 only starts the word.
        asm_clr     = (k_q == 2'd0);
        asm_cap     = (k_q != 2'd0);
        if (k_q == 2'd3) begin
          state_d = StDrain;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDrain: begin
        asm_cap    = 1'b1;
        inst_pc_d  = pc_q;
        pc_plus4_d = pc_q + PC_STEP;
        state_d    = StHold;
      end
      StHold: begin
        if (inst_ready_i) begin
          pc_d    = pc_q + PC_STEP;
          state_d = StIdle;
        end
      end
      StLoad: begin
        ld_gnt_o    = 1'b1;
        mem_wr_en_o = ld_req_i;
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = ld_wdata_i;
        if (!ld_req_i) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Redirect overrides everything above; a loader keeps the port until done.
    if (redir_valid_i) begin
      pc_d = redir_pc_i;
      k_d  = 2'd0;
      if (state_q != StLoad) begin
        state_d = StIdle;
      end
      if (state_q == StFetch || state_q == StDrain) begin
        asm_clr    = 1'b1;
        asm_cap    = 1'b0;
        inst_pc_d  = inst_pc_q;
        pc_plus4_d = pc_plus4_q;
      end
    end

    inst_valid_d = (state_d == StHold);
    fault_d      = (state_d == StFault);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      k_q          <= 2'd0;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      pc_plus4_q   <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      pc_plus4_q   <= pc_plus4_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_pc_o    = inst_pc_q;
  assign pc_plus4_o   = pc_plus4_q;
  assign fault_o      = fault_q;

endmodule
